// File: rtl/bp_stream_mmio_arbiter.sv
// Round-robin arbiter sharing one stream-MMIO bridge among I/O command requesters.
// Winners are queued in an in-order tag FIFO so responses route back to their source.
module bp_stream_mmio_arbiter #(
    parameter int num_req_p     = 2,
    parameter int msg_width_p   = 128,
    parameter int outstanding_p = 4,
    localparam int tag_w_lp = (num_req_p > 2) ? $clog2(num_req_p) : 1,
    localparam int ptr_w_lp = (outstanding_p > 2) ? $clog2(outstanding_p) : 1,
    localparam int cnt_w_lp = $clog2(outstanding_p + 1)
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic [num_req_p*msg_width_p-1:0]   req_cmd_i,
    input  logic [num_req_p-1:0]               req_cmd_v_i,
    output logic [num_req_p-1:0]               req_cmd_yumi_o,
    output logic [msg_width_p-1:0]             req_resp_o,
    output logic [num_req_p-1:0]               req_resp_v_o,
    input  logic [num_req_p-1:0]               req_resp_ready_i,
    output logic [msg_width_p-1:0]             io_cmd_o,
    output logic                               io_cmd_v_o,
    input  logic                               io_cmd_yumi_i,
    input  logic [msg_width_p-1:0]             io_resp_i,
    input  logic                               io_resp_v_i,
    output logic                               io_resp_ready_o,
    output logic [cnt_w_lp-1:0]                outstanding_o,
    output logic                               err_o
);

    typedef enum logic {IDLE, OFFER} state_e;

    state_e              state_r, state_n;
    logic [tag_w_lp-1:0] rr_r, grant_r, pick, head;
    logic                pick_v;
    logic [tag_w_lp-1:0] tag_mem [outstanding_p];
    logic [ptr_w_lp-1:0] wr_ptr_r, rd_ptr_r;
    logic [cnt_w_lp-1:0] cnt_r;
    logic                push, pop, tag_v, can_issue, err_set;

    assign tag_v     = (cnt_r != '0);
    assign head      = tag_mem[rd_ptr_r];
    assign can_issue = (cnt_r < cnt_w_lp'(outstanding_p));
    assign push      = (state_r == OFFER) & io_cmd_yumi_i;
    assign pop       = io_resp_v_i & io_resp_ready_o;

    // Descending scan so the valid closest to rr_r is the last (winning) assignment.
    always_comb begin
        int idx;
        pick   = rr_r;
        pick_v = 1'b0;
        idx    = 0;
        for (int k = num_req_p - 1; k >= 0; k--) begin
            idx = (int'(rr_r) + k) % num_req_p;
            if (req_cmd_v_i[idx]) begin
                pick   = tag_w_lp'(idx);
                pick_v = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state_r <= IDLE;
        else            state_r <= state_n;
    end

    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE:    if (pick_v && can_issue) state_n = OFFER;
            OFFER:   if (io_cmd_yumi_i)       state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        io_cmd_v_o     = (state_r == OFFER);
        req_cmd_yumi_o = '0;
        if (push) req_cmd_yumi_o[grant_r] = 1'b1;
    end

    assign io_cmd_o        = req_cmd_i[grant_r*msg_width_p +: msg_width_p];
    assign io_resp_ready_o = tag_v & req_resp_ready_i[head];
    assign req_resp_o      = io_resp_i;
    assign outstanding_o   = cnt_r;

    for (genvar g = 0; g < num_req_p; g++) begin : g_resp_v
        assign req_resp_v_o[g] = io_resp_v_i & tag_v & (head == tag_w_lp'(g));
    end

    assign err_set = (io_resp_v_i & ~tag_v)
                   | (io_cmd_yumi_i & ~io_cmd_v_o)
                   | ((state_r == OFFER) & ~req_cmd_v_i[grant_r]);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rr_r     <= '0;
            grant_r  <= '0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            cnt_r    <= '0;
            err_o    <= 1'b0;
        end else begin
            if (state_r == IDLE && state_n == OFFER) grant_r <= pick;
            if (push) begin
                rr_r     <= (grant_r == tag_w_lp'(num_req_p - 1)) ? '0 : grant_r + 1'b1;
                wr_ptr_r <= (wr_ptr_r == ptr_w_lp'(outstanding_p - 1)) ? '0 : wr_ptr_r + 1'b1;
            end
            if (pop)
                rd_ptr_r <= (rd_ptr_r == ptr_w_lp'(outstanding_p - 1)) ? '0 : rd_ptr_r + 1'b1;
            if (push && !pop)      cnt_r <= cnt_r + 1'b1;
            else if (pop && !push) cnt_r <= cnt_r - 1'b1;
            if (err_set) err_o <= 1'b1;
        end
    end

    // Entries are only read while tag_v, so the storage needs no reset.
    always_ff @(posedge clk_i) begin
        if (push) tag_mem[wr_ptr_r] <= grant_r;
    end

endmodule
